ip_rule_filter: RTL and testbench

Parametrised packet-header firewall stage: consumes a byte stream with ready/valid/last framing, captures source and destination IPv4 addresses at configurable offsets, and scans an external synchronous rule RAM for the first matching masked rule. It issues one permit/deny verdict per packet over a ready/valid handshake and maintains saturating permit/deny statistics. It sits between the ingress byte interface (UART/AXI-Stream adapter) and the forwarding/drop logic, replacing the fixed 40-byte, source-only, exact-match filter.

---
 rtl/fw_pkg.sv | 25 ++
 rtl/ip_rule_match.sv | 23 ++
 rtl/ip_rule_filter.sv | 200 ++++++++++++++++++++
 tb/tb_ip_rule_filter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_pkg.sv
// Shared definitions for the IPv4 rule filter: rule word layout, FSM states
// and a saturating counter helper.
package fw_pkg;

  // Rule word: {en, sel_dst, permit, mask[31:0], value[31:0]}
  localparam int RULE_W         = 67;
  localparam int RULE_EN        = 66;
  localparam int RULE_SEL_DST   = 65;
  localparam int RULE_PERMIT    = 64;
  localparam int RULE_MASK_LSB  = 32;
  localparam int RULE_VALUE_LSB = 0;

  typedef enum logic [1:0] {
    ST_RECV    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_SCAN    = 2'd2,
    ST_VERDICT = 2'd3
  } state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ip_rule_match.sv
// Combinational masked compare of one rule word against the captured
// source/destination addresses.
module ip_rule_match
  import fw_pkg::*;
(
  input  logic [RULE_W-1:0] rule_i,
  input  logic [31:0]       src_ip_i,
  input  logic [31:0]       dst_ip_i,
  output logic              hit_o,
  output logic              permit_o
);

  logic [31:0] mask;
  logic [31:0] value;
  logic [31:0] key;

  assign mask     = rule_i[RULE_MASK_LSB +: 32];
  assign value    = rule_i[RULE_VALUE_LSB +: 32];
  assign key      = rule_i[RULE_SEL_DST] ? dst_ip_i : src_ip_i;
  assign hit_o    = rule_i[RULE_EN] && ((key & mask) == (value & mask));
  assign permit_o = rule_i[RULE_PERMIT];

endmodule

// File: rtl/ip_rule_filter.sv
// Packet-header firewall stage: captures src/dst IPv4 addresses from a byte
// stream, scans the external rule RAM for the first masked match and returns
// one permit/deny verdict per packet, with saturating statistics.
module ip_rule_filter
  import fw_pkg::*;
#(
  parameter int HDR_BYTES      = 40,
  parameter int SRC_OFS        = 26,
  parameter int DST_OFS        = 30,
  parameter int RULE_DEPTH     = 256,
  parameter int ADDR_W         = (RULE_DEPTH > 1) ? $clog2(RULE_DEPTH) : 1,
  parameter int RD_LAT         = 1,
  parameter bit DEFAULT_PERMIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] rule_addr,
  output logic              rule_en,
  input  logic [RULE_W-1:0] rule_data,
  output logic              v_valid,
  input  logic              v_ready,
  output logic              v_permit,
  output logic              v_hit,
  output logic [ADDR_W-1:0] v_rule,
  output logic              v_malformed,
  output logic [31:0]       permit_cnt,
  output logic [31:0]       deny_cnt
);

  localparam int CNT_W = $clog2(HDR_BYTES + 1);
  localparam int CYC_W = $clog2(RULE_DEPTH + RD_LAT + 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        src_ip_q;
  logic [31:0]        dst_ip_q;
  logic [CYC_W-1:0]   scan_cyc_q;

  logic               s_ready_q;
  logic [ADDR_W-1:0]  rule_addr_q;
  logic               rule_en_q;
  logic               v_valid_q;
  logic               v_permit_q;
  logic               v_hit_q;
  logic [ADDR_W-1:0]  v_rule_q;
  logic               v_malformed_q;
  logic [31:0]        permit_cnt_q;
  logic [31:0]        deny_cnt_q;

  logic               accept;
  int                 beat_cnt;
  logic               data_ok;
  int                 data_idx;
  int                 next_k;
  logic               match_hit;
  logic               match_permit;

  assign accept   = s_valid && s_ready_q;
  assign beat_cnt = int'(cnt_q) + 1;
  // rule_data seen in scan cycle c answers the read issued in cycle c-RD_LAT
  assign data_ok  = (int'(scan_cyc_q) >= RD_LAT);
  assign data_idx = int'(scan_cyc_q) - RD_LAT;
  assign next_k   = int'(scan_cyc_q) + 1;

  ip_rule_match u_match (
    .rule_i   (rule_data),
    .src_ip_i (src_ip_q),
    .dst_ip_i (dst_ip_q),
    .hit_o    (match_hit),
    .permit_o (match_permit)
  );

  // Receive/scan/verdict FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RECV;
      cnt_q         <= '0;
      src_ip_q      <= '0;
      dst_ip_q      <= '0;
      scan_cyc_q    <= '0;
      s_ready_q     <= 1'b1;
      rule_addr_q   <= '0;
      rule_en_q     <= 1'b0;
      v_valid_q     <= 1'b0;
      v_permit_q    <= 1'b0;
      v_hit_q       <= 1'b0;
      v_rule_q      <= '0;
      v_malformed_q <= 1'b0;
      permit_cnt_q  <= '0;
      deny_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (accept) begin
            // Bytes arrive MSB first, so shifting in assembles big-endian.
            if (int'(cnt_q) >= SRC_OFS && int'(cnt_q) < SRC_OFS + 4)
              src_ip_q <= {src_ip_q[23:0], s_data};
            if (int'(cnt_q) >= DST_OFS && int'(cnt_q) < DST_OFS + 4)
              dst_ip_q <= {dst_ip_q[23:0], s_data};
            if (s_last) begin
              s_ready_q <= 1'b0;
              if (beat_cnt < HDR_BYTES) begin
                // Too short to hold both addresses: deny without scanning.
                state_q       <= ST_VERDICT;
                v_valid_q     <= 1'b1;
                v_permit_q    <= 1'b0;
                v_hit_q       <= 1'b0;
                v_rule_q      <= '0;
                v_malformed_q <= 1'b1;
              end else begin
                state_q     <= ST_SCAN;
                scan_cyc_q  <= '0;
                rule_addr_q <= '0;
                rule_en_q   <= 1'b1;
              end
            end else begin
              cnt_q <= CNT_W'(beat_cnt);
              if (beat_cnt == HDR_BYTES)
                state_q <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (accept && s_last) begin
            state_q     <= ST_SCAN;
            s_ready_q   <= 1'b0;
            scan_cyc_q  <= '0;
            rule_addr_q <= '0;
            rule_en_q   <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (data_ok && match_hit) begin
            state_q       <= ST_VERDICT;
            rule_en_q     <= 1'b0;
            rule_addr_q   <= '0;
            v_valid_q     <= 1'b1;
            v_permit_q    <= match_permit;
            v_hit_q       <= 1'b1;
            v_rule_q      <= ADDR_W'(data_idx);
            v_malformed_q <= 1'b0;
          end else if (data_ok && data_idx == RULE_DEPTH - 1) begin
            state_q       <= ST_VERDICT;
            rule_en_q     <= 1'b0;
            rule_addr_q   <= '0;
            v_valid_q     <= 1'b1;
            v_permit_q    <= DEFAULT_PERMIT;
            v_hit_q       <= 1'b0;
            v_rule_q      <= '0;
            v_malformed_q <= 1'b0;
          end else begin
            scan_cyc_q <= CYC_W'(next_k);
            if (next_k < RULE_DEPTH) begin
              rule_addr_q <= ADDR_W'(next_k);
              rule_en_q   <= 1'b1;
            end else begin
              rule_addr_q <= '0;
              rule_en_q   <= 1'b0;
            end
          end
        end

        ST_VERDICT: begin
          if (v_ready) begin
            state_q   <= ST_RECV;
            v_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            cnt_q     <= '0;
            src_ip_q  <= '0;
            dst_ip_q  <= '0;
            if (v_permit_q) permit_cnt_q <= sat_inc(permit_cnt_q);
            else            deny_cnt_q   <= sat_inc(deny_cnt_q);
          end
        end

        default: state_q <= ST_RECV;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign rule_addr   = rule_addr_q;
  assign rule_en     = rule_en_q;
  assign v_valid     = v_valid_q;
  assign v_permit    = v_permit_q;
  assign v_hit       = v_hit_q;
  assign v_rule      = v_rule_q;
  assign v_malformed = v_malformed_q;
  assign permit_cnt  = permit_cnt_q;
  assign deny_cnt    = deny_cnt_q;

endmodule

// File: tb/tb_ip_rule_filter.sv
// Self-checking bench for ip_rule_filter: directed packets against a bench
// rule RAM, a packet-level reference model checked every cycle, and literal
// expectations for the headline scenarios.
module tb_ip_rule_filter;

  localparam int HDR   = 40;
  localparam int DEPTH = 256;
  localparam int RDL   = 1;
  localparam int AW    = 8;
  localparam bit DEF_PERMIT = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [AW-1:0] rule_addr;
  logic          rule_en;
  logic [66:0]   rule_data = '0;
  logic          v_valid;
  logic          v_ready;
  logic          v_permit;
  logic          v_hit;
  logic [AW-1:0] v_rule;
  logic          v_malformed;
  logic [31:0]   permit_cnt;
  logic [31:0]   deny_cnt;

  ip_rule_filter #(
    .HDR_BYTES(HDR), .SRC_OFS(26), .DST_OFS(30), .RULE_DEPTH(DEPTH),
    .RD_LAT(RDL), .DEFAULT_PERMIT(DEF_PERMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .rule_addr(rule_addr), .rule_en(rule_en), .rule_data(rule_data),
    .v_valid(v_valid), .v_ready(v_ready), .v_permit(v_permit), .v_hit(v_hit),
    .v_rule(v_rule), .v_malformed(v_malformed),
    .permit_cnt(permit_cnt), .deny_cnt(deny_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External synchronous rule RAM, one cycle read latency.
  logic [66:0] ram [DEPTH];
  always @(posedge clk) if (rule_en) rule_data <= ram[rule_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [66:0] mk_rule(input bit en, input bit sel_dst, input bit permit,
                                          input logic [31:0] mask, input logic [31:0] value);
    return {en, sel_dst, permit, mask, value};
  endfunction

  task automatic clear_ram();
    for (int k = 0; k < DEPTH; k++) ram[k] = '0;
  endtask

  // ---------------- reference model / monitor ----------------
  logic [7:0] mon_bytes[$];
  bit         busy = 1'b0;
  int         base;          // cycle number of scan cycle 0
  bit         e_mal, e_hit, e_permit;
  int         e_rule, e_scan, e_need;
  int         m_permit = 0, m_deny = 0;
  bit         seen;
  int         rise_scan;
  logic       got_permit, got_hit, got_mal;
  logic [AW-1:0] got_rule;

  // Verdict and timing straight from the packet and the rule table.
  task automatic predict();
    int len;
    logic [31:0] src, dst, key;
    logic [66:0] r;
    len      = mon_bytes.size();
    e_mal    = (len < HDR);
    e_hit    = 1'b0;
    e_rule   = 0;
    e_permit = DEF_PERMIT;
    e_scan   = DEPTH + RDL;
    if (e_mal) begin
      e_permit = 1'b0;
      e_scan   = 0;
    end else begin
      src = {mon_bytes[26], mon_bytes[27], mon_bytes[28], mon_bytes[29]};
      dst = {mon_bytes[30], mon_bytes[31], mon_bytes[32], mon_bytes[33]};
      for (int k = 0; k < DEPTH; k++) begin
        r   = ram[k];
        key = r[65] ? dst : src;
        if (r[66] && ((key & r[63:32]) == (r[31:0] & r[63:32]))) begin
          e_hit    = 1'b1;
          e_rule   = k;
          e_permit = r[64];
          e_scan   = k + RDL + 1;
          break;
        end
      end
    end
    e_need = e_hit ? e_rule : DEPTH - 1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int off;
    if (rst) begin
      check("reset_flags", {s_ready, rule_en, v_valid, v_permit, v_hit, v_malformed}, 6'b100000);
      check("reset_addr", {rule_addr, v_rule}, '0);
      check("reset_cnt", {permit_cnt, deny_cnt}, '0);
      busy = 1'b0;
      mon_bytes.delete();
      m_permit = 0;
      m_deny   = 0;
    end else begin
      check("s_ready", s_ready, !busy);
      check("permit_cnt", permit_cnt, m_permit);
      check("deny_cnt", deny_cnt, m_deny);
      if (busy) begin
        off = cyc - base;
        if (e_mal) begin
          check("rule_en_malformed", rule_en, 1'b0);
        end else if (off <= e_need) begin
          check("rule_en_scan", rule_en, 1'b1);
          check("rule_addr_scan", rule_addr, off);
        end else if (rule_en) begin
          check("rule_addr_extra", rule_addr, off);
          check("rule_en_range", off < DEPTH, 1'b1);
        end
        check("v_valid", v_valid, off >= e_scan);
        if (v_valid) begin
          check("v_permit", v_permit, e_permit);
          check("v_hit", v_hit, e_hit);
          check("v_rule", v_rule, e_rule);
          check("v_malformed", v_malformed, e_mal);
          if (!seen) begin
            seen       = 1'b1;
            rise_scan  = off;
            got_permit = v_permit;
            got_hit    = v_hit;
            got_rule   = v_rule;
            got_mal    = v_malformed;
          end
          if (v_ready) begin
            busy = 1'b0;
            if (e_permit) m_permit++;
            else          m_deny++;
          end
        end
      end else begin
        check("rule_en_idle", rule_en, 1'b0);
        check("v_valid_idle", v_valid, 1'b0);
      end
      if (s_valid && s_ready) begin
        mon_bytes.push_back(s_data);
        if (s_last) begin
          predict();
          mon_bytes.delete();
          busy = 1'b1;
          seen = 1'b0;
          base = cyc + 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pkt[$];

  task automatic build_pkt(input int len, input logic [31:0] src, input logic [31:0] dst);
    logic [7:0] b;
    pkt.delete();
    for (int i = 0; i < len; i++) begin
      b = 8'(i * 7 + 3);
      if (i >= 26 && i < 30) b = src[8*(29-i) +: 8];
      if (i >= 30 && i < 34) b = dst[8*(33-i) +: 8];
      pkt.push_back(b);
    end
  endtask

  task automatic send_pkt();
    int n;
    for (int i = 0; i < pkt.size(); i++) begin
      s_valid = 1'b1;
      s_data  = pkt[i];
      s_last  = (i == pkt.size() - 1);
      n = 0;
      do begin @(negedge clk); n++; end while (!s_ready && n < 1000);
      if (!s_ready) begin
        check("send_timeout", s_ready, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 2000) begin @(posedge clk); n++; end
    check("verdict_timeout", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic expect_last(input string tag, input bit permit, input bit hit,
                             input int rule, input bit mal, input int scan);
    check({tag, "_permit"}, got_permit, permit);
    check({tag, "_hit"}, got_hit, hit);
    check({tag, "_rule"}, got_rule, rule);
    check({tag, "_malformed"}, got_mal, mal);
    check({tag, "_latency"}, rise_scan, scan);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; v_ready = 1'b1;
    clear_ram();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Exact source deny at rule 3; rules 0-2 would match but are disabled.
    for (int k = 0; k < 3; k++) ram[k] = mk_rule(0, 0, 0, 32'hFFFF_FFFF, 32'h0A00_0005);
    ram[3] = mk_rule(1, 0, 0, 32'hFFFF_FFFF, 32'h0A00_0005);
    build_pkt(40, 32'h0A00_0005, 32'hC0A8_014D);
    send_pkt(); wait_done();
    expect_last("t1", 0, 1, 3, 0, 5);
    check("t1_deny_cnt", deny_cnt, 1);
    check("t1_permit_cnt", permit_cnt, 0);

    // Destination prefix permit at rule 0 beats exact deny at rule 1.
    clear_ram();
    ram[0] = mk_rule(1, 1, 1, 32'hFFFF_FF00, 32'hC0A8_0100);
    ram[1] = mk_rule(1, 1, 0, 32'hFFFF_FFFF, 32'hC0A8_014D);
    build_pkt(40, 32'h0102_0304, 32'hC0A8_014D);
    send_pkt(); wait_done();
    expect_last("t2", 1, 1, 0, 0, 2);
    check("t2_permit_cnt", permit_cnt, 1);

    // No rule matches: default permit after the full table.
    clear_ram();
    ram[7]   = mk_rule(1, 1, 0, 32'hFFFF_FFFF, 32'hC0A8_014E);
    ram[9]   = mk_rule(0, 0, 0, 32'h0000_0000, 32'h0000_0000);
    ram[255] = mk_rule(1, 0, 0, 32'hFFFF_FFFF, 32'h0102_0304);
    build_pkt(40, 32'h0A00_0006, 32'hC0A8_014D);
    send_pkt(); wait_done();
    expect_last("t3", 1, 0, 0, 0, 257);
    check("t3_permit_cnt", permit_cnt, 2);

    // Only the last table entry matches.
    ram[255] = mk_rule(1, 0, 0, 32'hFFFF_FFFF, 32'h0A00_0006);
    send_pkt(); wait_done();
    expect_last("t3b", 0, 1, 255, 0, 257);
    check("t3b_deny_cnt", deny_cnt, 2);

    // Zero-mask wildcard at rule 9, 41-byte packet through the drain path.
    ram[9] = mk_rule(1, 0, 1, 32'h0000_0000, 32'hDEAD_BEEF);
    build_pkt(41, 32'h0A00_0006, 32'hC0A8_014D);
    send_pkt(); wait_done();
    expect_last("t3c", 1, 1, 9, 0, 11);

    // Short packets are malformed and denied the next cycle.
    build_pkt(20, 32'h0A00_0006, 32'hC0A8_014D);
    send_pkt(); wait_done();
    expect_last("t4", 0, 0, 0, 1, 0);
    build_pkt(39, 32'h0A00_0006, 32'hC0A8_014D);
    send_pkt(); wait_done();
    expect_last("t4b", 0, 0, 0, 1, 0);
    check("t4_deny_cnt", deny_cnt, 4);

    // Verdict backpressure with the next packet already waiting.
    v_ready = 1'b0;
    build_pkt(64, 32'h0A00_0006, 32'hC0A8_0101);
    send_pkt();
    build_pkt(40, 32'h0A00_0007, 32'hC0A8_014E);
    fork
      send_pkt();
      begin
        int n = 0;
        while (!v_valid && n < 1000) begin @(posedge clk); n++; end
        repeat (10) @(posedge clk);
        #1;
        expect_last("t5a", 1, 1, 9, 0, 11);
        check("t5_held_bytes", mon_bytes.size(), 0);
        check("t5_s_ready_held", s_ready, 1'b0);
        v_ready = 1'b1;
      end
    join
    wait_done();
    expect_last("t5b", 0, 1, 7, 0, 9);
    check("t5_permit_cnt", permit_cnt, 4);
    check("t5_deny_cnt", deny_cnt, 5);

    // Reset in the middle of a full-table scan.
    clear_ram();
    build_pkt(40, 32'h0A00_0005, 32'hC0A8_014D);
    send_pkt();
    repeat (50) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_v_valid", v_valid, 1'b0);
    check("t6_rule_en", rule_en, 1'b0);
    check("t6_s_ready", s_ready, 1'b1);
    check("t6_deny_cnt", deny_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Normal operation resumes after reset.
    ram[0] = mk_rule(1, 0, 1, 32'hFFFF_0000, 32'h0A00_0000);
    send_pkt(); wait_done();
    expect_last("t7", 1, 1, 0, 0, 2);
    check("t7_permit_cnt", permit_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
